// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: icodes, ALU functions, condition codes, stat codes and the cc type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;
    localparam logic [3:0] F_MUL = 4'h4;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_XOR,
        ALU_MUL
    } alu_fun_t;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [1:0] STAT_INS = 2'b00;
    localparam logic [1:0] STAT_AOK = 2'b01;
    localparam logic [1:0] STAT_HLT = 2'b10;
    localparam logic [1:0] STAT_ADR = 2'b11;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational Y86-64 ALU producing the result and {ZF,SF,OF}.
// The multiply function exists only when EXEC_MUL_EN is defined.
module exec_alu
    import y86_pkg::*;
#(
    parameter int unsigned DW = 64
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_fun_t      fun,
    output logic [DW-1:0] result,
    output logic          zf,
    output logic          sf,
    output logic          of
);

`ifdef EXEC_MUL_EN
    logic [2*DW-1:0] prod;
    assign prod = {{DW{b[DW-1]}}, b} * {{DW{a[DW-1]}}, a};
`endif

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (fun)
            ALU_ADD: begin
                result = b + a;
                of     = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
            end
            ALU_SUB: begin
                result = b - a;
                of     = (a[DW-1] != b[DW-1]) && (result[DW-1] != b[DW-1]);
            end
            ALU_AND: result = b & a;
            ALU_XOR: result = b ^ a;
`ifdef EXEC_MUL_EN
            // Product fits only if the upper half is a pure sign extension of bit DW-1.
            ALU_MUL: begin
                result = prod[DW-1:0];
                of     = (prod[2*DW-1:DW-1] != '0) && (prod[2*DW-1:DW-1] != '1);
            end
`endif
            default: result = '0;
        endcase
    end

    assign zf = (result == '0);
    assign sf = result[DW-1];

endmodule

// File: rtl/execute.sv
// Y86-64 execute stage: operand muxes, ALU, condition codes, cmov/jXX condition and the E->M register.
// Define EXEC_MUL_EN to enable OPq ifun 4 (mulq); otherwise it is treated as an invalid instruction.
module execute
    import y86_pkg::*;
#(
    parameter int unsigned DW       = 64,
    parameter logic [2:0]  CC_RESET = 3'b100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          M_bubble,
    input  logic [1:0]    E_stat,
    input  logic [3:0]    E_icode,
    input  logic [3:0]    E_ifun,
    input  logic [DW-1:0] E_valA,
    input  logic [DW-1:0] E_valB,
    input  logic [DW-1:0] E_valC,
    input  logic [3:0]    E_dstE,
    input  logic [3:0]    E_dstM,
    input  logic [1:0]    m_stat,
    input  logic [1:0]    W_stat,
    output logic [DW-1:0] e_valE,
    output logic [3:0]    e_dstE,
    output logic          e_Cnd,
    output logic [2:0]    cc,
    output logic [1:0]    M_stat,
    output logic [3:0]    M_icode,
    output logic          M_Cnd,
    output logic [DW-1:0] M_valE,
    output logic [DW-1:0] M_valA,
    output logic [3:0]    M_dstE,
    output logic [3:0]    M_dstM
);

    localparam logic [DW-1:0] POS8 = DW'(8);
    localparam logic [DW-1:0] NEG8 = ~POS8 + 1'b1;
`ifdef EXEC_MUL_EN
    localparam logic [3:0] IFUN_MAX = F_MUL;
`else
    localparam logic [3:0] IFUN_MAX = F_XOR;
`endif

    logic [DW-1:0] alu_a, alu_b, alu_res;
    alu_fun_t      alu_fun;
    logic          alu_zf, alu_sf, alu_of;
    logic          op_bad, set_cc, cond_true;
    cc_t           cc_q;

    always_comb begin
        alu_a = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:             alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
            I_CALL, I_PUSHQ:             alu_a = NEG8;
            I_RET, I_POPQ:               alu_a = POS8;
            default:                     alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
            default: alu_b = '0;
        endcase
    end

    always_comb begin
        alu_fun = ALU_ADD;
        if (E_icode == I_OPQ) begin
            case (E_ifun)
                F_SUB:   alu_fun = ALU_SUB;
                F_AND:   alu_fun = ALU_AND;
                F_XOR:   alu_fun = ALU_XOR;
`ifdef EXEC_MUL_EN
                F_MUL:   alu_fun = ALU_MUL;
`endif
                default: alu_fun = ALU_ADD;
            endcase
        end
    end

    exec_alu #(.DW(DW)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .fun    (alu_fun),
        .result (alu_res),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    // An unsupported OPq function zeroes the result, blocks cc and is flagged INS in M.
    assign op_bad = (E_icode == I_OPQ) && (E_ifun > IFUN_MAX);
    assign e_valE = op_bad ? '0 : alu_res;
    assign set_cc = (E_icode == I_OPQ) && !op_bad && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

    always_comb begin
        cond_true = 1'b0;
        case (E_ifun)
            C_YES:   cond_true = 1'b1;
            C_LE:    cond_true = (cc_q.sf ^ cc_q.of) | cc_q.zf;
            C_L:     cond_true = cc_q.sf ^ cc_q.of;
            C_E:     cond_true = cc_q.zf;
            C_NE:    cond_true = ~cc_q.zf;
            C_GE:    cond_true = ~(cc_q.sf ^ cc_q.of);
            C_G:     cond_true = ~(cc_q.sf ^ cc_q.of) & ~cc_q.zf;
            default: cond_true = 1'b0;
        endcase
    end

    assign e_Cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) && cond_true;
    assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? REG_NONE : E_dstE;
    assign cc     = cc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q    <= cc_t'(CC_RESET);
            M_stat  <= STAT_AOK;
            M_icode <= I_NOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= REG_NONE;
            M_dstM  <= REG_NONE;
        end else begin
            if (set_cc) begin
                cc_q <= '{zf: alu_zf, sf: alu_sf, of: alu_of};
            end
            if (M_bubble) begin
                M_stat  <= STAT_AOK;
                M_icode <= I_NOP;
                M_Cnd   <= 1'b0;
                M_valE  <= '0;
                M_valA  <= '0;
                M_dstE  <= REG_NONE;
                M_dstM  <= REG_NONE;
            end else begin
                M_stat  <= op_bad ? STAT_INS : E_stat;
                M_icode <= E_icode;
                M_Cnd   <= e_Cnd;
                M_valE  <= e_valE;
                M_valA  <= E_valA;
                M_dstE  <= e_dstE;
                M_dstM  <= E_dstM;
            end
        end
    end

endmodule
